// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arb_pkg : shared types and constants for the memory port arbiter
// Revision    : 1.0
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int MAX_REQ    = 8;
  localparam int MAX_ID_W   = 3;
  localparam int REQ_IFETCH = 0;
  localparam int REQ_DATA   = 1;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
    logic                is_write;
  } rsp_entry_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : round-robin picker, first valid requester at or after i_ptr
// Revision   : 1.0
// ---------------------------------------------------------------------------
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_winner,
  output logic               o_any
);

  always_comb begin
    o_any    = |i_valid;
    o_winner = '0;
    // Lowest valid index overall covers the wrapped case; a valid index at
    // or above the pointer, found in the second pass, takes precedence.
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (i_valid[j]) o_winner = ID_W'(j);
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (i_valid[j] && (j >= int'(i_ptr))) o_winner = ID_W'(j);
    end
    o_grant = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      o_grant[j] = o_any && (o_winner == ID_W'(j));
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter : round-robin sharing of one fixed-latency memory port
// Revision         : 1.0
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_address,
  input  logic [NUM_REQ-1:0]        i_req_write,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_rdata,
  output logic                      o_mem_en,
  output logic                      o_mem_we,
  output logic [ADDR_W-1:0]         o_mem_address,
  output logic [DATA_W-1:0]         o_mem_wdata,
  input  logic [DATA_W-1:0]         i_mem_rdata
);

  localparam int ID_W = id_width(NUM_REQ);

  logic [ID_W-1:0]    r_rr_ptr;
  rsp_entry_t         r_pipe [MEM_LATENCY];
  logic [NUM_REQ-1:0] w_valid;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_winner;
  logic               w_any;
  rsp_entry_t         w_last;

  // Nothing is granted or issued while reset is held.
  assign w_valid = rst ? '0 : i_req_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .i_valid  (w_valid),
    .i_ptr    (r_rr_ptr),
    .o_grant  (w_grant),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  always_comb begin
    o_req_ready   = w_grant;
    o_mem_en      = w_any;
    o_mem_we      = 1'b0;
    o_mem_address = '0;
    o_mem_wdata   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_grant[j]) begin
        o_mem_we      = i_req_write[j];
        o_mem_address = i_req_address[j*ADDR_W +: ADDR_W];
        o_mem_wdata   = i_req_wdata[j*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      if (w_any) begin
        r_rr_ptr <= (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
      end
      r_pipe[0] <= '{valid: w_any, id: MAX_ID_W'(w_winner), is_write: o_mem_we};
      for (int i = 1; i < MEM_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_last = r_pipe[MEM_LATENCY-1];

  always_comb begin
    for (int j = 0; j < NUM_REQ; j++) begin
      o_rsp_valid[j] = w_last.valid && (w_last.id == MAX_ID_W'(j));
    end
    o_rsp_rdata = (w_last.valid && !w_last.is_write) ? i_mem_rdata : '0;
  end

endmodule
`default_nettype wire
